// File: rtl/control_sequencer.sv
// Hardwired multicycle control unit for the cpu_phase2 datapath.
// Steps through RESET/T0..T7/HALT and decodes IR[31:27] into per-cycle strobes.
module control_sequencer #(
  parameter logic [4:0] ALU_ADD = 5'b00011,
  parameter logic [4:0] ALU_SUB = 5'b00100,
  parameter logic [4:0] ALU_AND = 5'b00101,
  parameter logic [4:0] ALU_OR  = 5'b00110
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  output logic        PCout, ZHighOut, ZLowOut, MDRout, HIout, LOout, Cout, BAout,
  output logic        MARin, Zin, PCin, MDRin, IRin, Yin, Rin, Rout, CONin,
  output logic        Gra, Grb, Grc,
  output logic        IncPC, MDRread, W_sig,
  output logic [4:0]  operation,
  output logic        Run
);
  typedef enum logic [3:0] {
    S_RESET = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
    S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_T7 = 4'd8, S_HALT = 4'd9
  } state_t;

  localparam logic [4:0] OP_LD = 5'b00000, OP_LDI = 5'b00001, OP_ST = 5'b00010,
                         OP_ADD = 5'b00011, OP_SUB = 5'b00100, OP_AND = 5'b00101,
                         OP_OR = 5'b00110, OP_BR = 5'b10011, OP_JR = 5'b10100,
                         OP_MFHI = 5'b11000, OP_MFLO = 5'b11001, OP_HALT = 5'b11011;

  state_t     state, nxt;
  logic [4:0] opc;
  logic       is_ld, is_ldi, is_st, is_alu, is_br, addr_calc;
  logic [4:0] alu_op;
  logic       unused_ir;

  assign opc       = IR[31:27];
  assign unused_ir = ^IR[26:0];
  assign is_ld     = (opc == OP_LD);
  assign is_ldi    = (opc == OP_LDI);
  assign is_st     = (opc == OP_ST);
  assign is_br     = (opc == OP_BR);
  assign is_alu    = (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_AND) || (opc == OP_OR);
  assign addr_calc = is_ld || is_ldi || is_st;

  always_comb begin
    case (opc)
      OP_SUB:  alu_op = ALU_SUB;
      OP_AND:  alu_op = ALU_AND;
      OP_OR:   alu_op = ALU_OR;
      default: alu_op = ALU_ADD;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= S_RESET;
    else     state <= nxt;
  end

  always_comb begin
    nxt = S_T0;
    case (state)
      S_RESET: nxt = S_T0;
      S_T0:    nxt = S_T1;
      S_T1:    nxt = S_T2;
      S_T2:    nxt = S_T3;
      S_T3: begin
        if (opc == OP_HALT)                      nxt = S_HALT;
        else if (addr_calc || is_alu || is_br)   nxt = S_T4;
      end
      S_T4:    nxt = S_T5;
      S_T5:    if (is_ld || is_st || is_br) nxt = S_T6;
      S_T6:    if (is_ld || is_st) nxt = S_T7;
      S_T7:    nxt = S_T0;
      S_HALT:  nxt = S_HALT;
      default: nxt = S_T0;  // unused encodings recover into fetch
    endcase
  end

  always_comb begin
    {PCout, ZHighOut, ZLowOut, MDRout, HIout, LOout, Cout, BAout} = '0;
    {MARin, Zin, PCin, MDRin, IRin, Yin, Rin, Rout, CONin}        = '0;
    {Gra, Grb, Grc, IncPC, MDRread, W_sig}                        = '0;
    operation = '0;
    Run       = 1'b0;
    case (state)
      S_T0: begin Run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      S_T1: begin Run = 1'b1; ZLowOut = 1'b1; PCin = 1'b1; MDRread = 1'b1; MDRin = 1'b1; end
      S_T2: begin Run = 1'b1; MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        Run = 1'b1;
        case (opc)
          OP_LD, OP_LDI, OP_ST:        begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          OP_BR:   begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
          OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          OP_MFHI: begin Gra = 1'b1; Rin = 1'b1; HIout = 1'b1; end
          OP_MFLO: begin Gra = 1'b1; Rin = 1'b1; LOout = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        Run = 1'b1;
        if (addr_calc)   begin Cout = 1'b1; operation = ALU_ADD; Zin = 1'b1; end
        else if (is_alu) begin Grc = 1'b1; Rout = 1'b1; operation = alu_op; Zin = 1'b1; end
        else if (is_br)  begin PCout = 1'b1; Yin = 1'b1; end
      end
      S_T5: begin
        Run = 1'b1;
        if (is_ld || is_st)        begin ZLowOut = 1'b1; MARin = 1'b1; end
        else if (is_ldi || is_alu) begin ZLowOut = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else if (is_br)            begin Cout = 1'b1; operation = ALU_ADD; Zin = 1'b1; end
      end
      S_T6: begin
        Run = 1'b1;
        if (is_ld)      begin MDRread = 1'b1; MDRin = 1'b1; end
        else if (is_st) begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
        else if (is_br) begin ZLowOut = 1'b1; PCin = CON_FF; end
      end
      S_T7: begin
        Run = 1'b1;
        if (is_ld)      begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else if (is_st) W_sig = 1'b1;
      end
      default: ;
    endcase
  end
endmodule
